// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: decodes one RV32 integer op and drives an external combinational ALU (two passes for branches).
// Latency from transfer: illegal 1 cycle, ALU op / AUIPC 2 cycles, branch 3 cycles to out_valid.
// Backpressure: one op in flight; in_ready only in IDLE, response held stable in RESP until out_ready.
module alu_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_class,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, b_q, pc_q, imm_q;
    logic [2:0]      code_q;
    logic            branch_q;   // op needs the second (target) pass
    logic            inv_q;      // branch taken = ~result[0] (BNE/BGE)
    logic [XLEN-1:0] result_q, target_q;
    logic            zero_q, taken_q, illegal_q;

    logic [XLEN-1:0] dec_a, dec_b;
    logic [2:0]      dec_code;
    logic            dec_illegal, dec_branch, dec_inv;

    // Decode the offered instruction into operands and an ALU code.
    always_comb begin
        dec_a       = in_rs1;
        dec_b       = in_rs2;
        dec_code    = ALU_ADD;
        dec_illegal = 1'b0;
        dec_branch  = 1'b0;
        dec_inv     = 1'b0;
        unique case (in_class)
            2'b00, 2'b01: begin
                if (in_class == 2'b01) dec_b = in_imm;
                case (in_funct3)
                    3'b000:  dec_code = (in_class == 2'b00 && in_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b100:  dec_code = ALU_XOR;
                    3'b110:  dec_code = ALU_OR;
                    3'b111:  dec_code = ALU_AND;
                    3'b010:  dec_code = ALU_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            2'b10: begin
                dec_branch = 1'b1;
                case (in_funct3)
                    3'b000:  dec_code = ALU_EQ;
                    3'b001: begin dec_code = ALU_EQ;  dec_inv = 1'b1; end
                    3'b100:  dec_code = ALU_SLT;
                    3'b101: begin dec_code = ALU_SLT; dec_inv = 1'b1; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: begin
                dec_a = in_pc;
                dec_b = in_imm;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, handshakes and ALU drive per state.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = dec_illegal ? RESP : EXEC1;
            end
            EXEC1: begin
                alu_a       = a_q;
                alu_b       = b_q;
                alu_control = code_q;
                state_d     = branch_q ? EXEC2 : RESP;
            end
            EXEC2: begin
                alu_a   = pc_q;
                alu_b   = imm_q;
                state_d = RESP;
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
        endcase
    end

    // Latch the op on transfer and capture ALU results in each pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            code_q    <= ALU_ADD;
            branch_q  <= 1'b0;
            inv_q     <= 1'b0;
            result_q  <= '0;
            target_q  <= '0;
            zero_q    <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= dec_a;
                        b_q       <= dec_b;
                        pc_q      <= in_pc;
                        imm_q     <= in_imm;
                        code_q    <= dec_code;
                        branch_q  <= dec_branch;
                        inv_q     <= dec_inv;
                        result_q  <= '0;
                        target_q  <= '0;
                        zero_q    <= 1'b0;
                        taken_q   <= 1'b0;
                        illegal_q <= dec_illegal;
                    end
                end
                EXEC1: begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                end
                EXEC2: begin
                    target_q <= alu_result;
                    taken_q  <= result_q[0] ^ inv_q;
                end
                default: ;
            endcase
        end
    end

    assign out_result  = result_q;
    assign out_zero    = zero_q;
    assign out_taken   = taken_q;
    assign out_target  = target_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the drive side, reference model feeding a scoreboard queue.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  in_class;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_control;
    logic        alu_zero;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_target;
    logic        out_zero, out_taken, out_illegal;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1, rs2, imm, pc;
    } op_t;

    typedef struct {
        logic [31:0] result, target, a, b;
        logic        zero, taken, illegal, branch;
        logic [2:0]  code;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_issue_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_taken(out_taken),
        .out_target(out_target), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU.
    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = ~alu_a;
            3'd3: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a | alu_b;
            3'd5: alu_result = alu_a ^ alu_b;
            3'd6: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = {31'b0, alu_a == alu_b};
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one instruction.
    function automatic exp_t model(input op_t o);
        exp_t        e;
        logic [31:0] bv;
        logic        lt, eq;
        e = '{result: 0, target: 0, a: 0, b: 0, zero: 0, taken: 0,
              illegal: 0, branch: 0, code: 0, lat: 2};
        bv = (o.cls == 2'b01) ? o.imm : o.rs2;
        lt = $signed(o.rs1) < $signed(bv);
        eq = (o.rs1 == bv);
        e.a = o.rs1;
        e.b = bv;
        case (o.cls)
            2'b00, 2'b01: begin
                case (o.f3)
                    3'b000: if (o.cls == 2'b00 && o.f7) begin e.code = 1; e.result = o.rs1 - bv; end
                            else begin e.code = 0; e.result = o.rs1 + bv; end
                    3'b100: begin e.code = 5; e.result = o.rs1 ^ bv; end
                    3'b110: begin e.code = 4; e.result = o.rs1 | bv; end
                    3'b111: begin e.code = 3; e.result = o.rs1 & bv; end
                    3'b010: begin e.code = 6; e.result = {31'b0, lt}; end
                    default: e.illegal = 1;
                endcase
            end
            2'b10: begin
                e.branch = 1;
                e.lat    = 3;
                e.target = o.pc + o.imm;
                case (o.f3)
                    3'b000: begin e.code = 7; e.result = {31'b0, eq}; e.taken = eq;  end
                    3'b001: begin e.code = 7; e.result = {31'b0, eq}; e.taken = !eq; end
                    3'b100: begin e.code = 6; e.result = {31'b0, lt}; e.taken = lt;  end
                    3'b101: begin e.code = 6; e.result = {31'b0, lt}; e.taken = !lt; end
                    default: e.illegal = 1;
                endcase
            end
            default: begin
                e.a = o.pc; e.b = o.imm; e.code = 0; e.result = o.pc + o.imm;
            end
        endcase
        if (e.illegal) begin
            e.result = 0; e.target = 0; e.taken = 0; e.branch = 0;
            e.a = 0; e.b = 0; e.code = 0; e.lat = 1;
        end
        e.zero = !e.illegal && (e.result == 32'd0);
        return e;
    endfunction

    task automatic present(input op_t o);
        in_class = o.cls; in_funct3 = o.f3; in_funct7b5 = o.f7;
        in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm; in_pc = o.pc;
        in_valid = 1'b1;
    endtask

    // Wait at negedges until the op is accepted; returns with the transfer edge done.
    task automatic transfer;
        int n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check("accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Issue one op, check ALU drive, latency, response and backpressure hold.
    task automatic run_op(input op_t o, input int stall);
        exp_t cur, got;
        int   lat;
        @(negedge clk);
        present(o);
        cur = model(o);
        sb.push_back(cur);
        transfer();
        lat = 1;
        while (!out_valid && lat < 10) begin
            if (lat == 1) begin
                check("exec1_code", 32'(alu_control), 32'(cur.code));
                check("exec1_a", alu_a, cur.a);
                check("exec1_b", alu_b, cur.b);
            end
            if (lat == 2 && cur.branch) begin
                check("exec2_code", 32'(alu_control), 32'd0);
                check("exec2_a", alu_a, o.pc);
                check("exec2_b", alu_b, o.imm);
            end
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(cur.lat));
        if (sb.size() == 0) begin
            check("sb_empty_on_resp", 32'd1, 32'd0);
            return;
        end
        got = sb.pop_front();
        for (int k = 0; k <= stall; k++) begin
            if (k < stall) out_ready = 1'b0;
            else           out_ready = 1'b1;
            if (k > 0) in_valid = 1'b1;   // offered during RESP, must be ignored
            check("out_valid", 32'(out_valid), 32'd1);
            check("in_ready_resp", 32'(in_ready), 32'd0);
            check("out_result", out_result, got.result);
            check("out_zero", 32'(out_zero), 32'(got.zero));
            check("out_taken", 32'(out_taken), 32'(got.taken));
            check("out_target", out_target, got.target);
            check("out_illegal", 32'(out_illegal), 32'(got.illegal));
            check("resp_alu_ctl", 32'(alu_control), 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("ready_back", 32'(in_ready), 32'd1);
    endtask

    op_t dir[$];

    initial begin
        op_t o;
        int  seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_class = 0; in_funct3 = 0; in_funct7b5 = 0;
        in_rs1 = 0; in_rs2 = 0; in_imm = 0; in_pc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_flags", {29'b0, out_zero, out_taken, out_illegal}, 32'd0);
        check("rst_out_target", out_target, 32'd0);
        check("rst_alu", alu_a | alu_b | 32'(alu_control), 32'd0);
        rst = 1'b0;

        //          cls    f3      f7    rs1           rs2     imm           pc
        dir.push_back('{2'b00, 3'b000, 1'b1, 32'd10,       32'd3,  32'd0,        32'd0});
        dir.push_back('{2'b01, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd0,  32'd1,        32'd0});
        dir.push_back('{2'b10, 3'b001, 1'b0, 32'd5,        32'd5,  32'h10,       32'h80000000});
        dir.push_back('{2'b00, 3'b001, 1'b0, 32'd7,        32'd2,  32'd0,        32'd0});
        dir.push_back('{2'b00, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd1,  32'd0,        32'd0});
        dir.push_back('{2'b01, 3'b100, 1'b0, 32'hF0F0F0F0, 32'd0,  32'h0FF00FF0, 32'd0});
        dir.push_back('{2'b00, 3'b110, 1'b0, 32'h00FF0000, 32'h0000FF00, 32'd0,  32'd0});
        dir.push_back('{2'b01, 3'b111, 1'b0, 32'h12345678, 32'd0,  32'hFFFF0000, 32'd0});
        dir.push_back('{2'b01, 3'b000, 1'b1, 32'd100,      32'd0,  32'hFFFFFFFF, 32'd0});
        dir.push_back('{2'b11, 3'b000, 1'b0, 32'd0,        32'd0,  32'hFFFFF000, 32'h00001000});
        dir.push_back('{2'b10, 3'b000, 1'b0, 32'd9,        32'd9,  32'hFFFFFFF8, 32'h00000100});
        dir.push_back('{2'b10, 3'b100, 1'b0, 32'hFFFFFFFE, 32'd1,  32'd4,        32'h00000200});
        dir.push_back('{2'b10, 3'b101, 1'b0, 32'hFFFFFFFE, 32'd1,  32'd4,        32'h00000300});
        dir.push_back('{2'b10, 3'b010, 1'b0, 32'd1,        32'd1,  32'd4,        32'h00000400});
        dir.push_back('{2'b01, 3'b101, 1'b0, 32'd1,        32'd0,  32'd4,        32'd0});

        foreach (dir[i]) run_op(dir[i], (i == 4) ? 5 : 0);

        // Reset during the second pass of a BEQ discards it.
        o = '{2'b10, 3'b000, 1'b0, 32'd3, 32'd3, 32'd8, 32'h40};
        @(negedge clk);
        present(o);
        transfer();          // now in EXEC1
        @(negedge clk);      // now in EXEC2
        check("pre_rst_exec2", 32'(alu_a), 32'h40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_outs", out_result | out_target | {29'b0, out_zero, out_taken, out_illegal}, 32'd0);
        seen = 0;
        out_ready = 1'b1;
        repeat (8) begin @(negedge clk); if (out_valid) seen++; end
        out_ready = 1'b0;
        check("no_resp_after_rst", 32'(seen), 32'd0);

        for (int i = 0; i < 20; i++) begin
            o.cls = 2'($urandom_range(0, 3));
            o.f3  = 3'($urandom_range(0, 7));
            o.f7  = 1'($urandom_range(0, 1));
            o.rs1 = $urandom;
            o.rs2 = ($urandom_range(0, 2) == 0) ? o.rs1 : $urandom;
            o.imm = $urandom;
            o.pc  = $urandom;
            run_op(o, int'($urandom_range(0, 2)));
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
